// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests to imem,
// in-order response buffering with PC, redirect flush and stale discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_aclk,
  input  logic        i_reset,
  input  logic [31:0] i_br_addr,
  input  logic        i_br_valid,
  input  logic        i_fetch_en,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_instr_valid,
  input  logic        i_decode_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc;
  cnt_t        inflight;
  cnt_t        discard;

  logic [31:0] pcq [FIFO_DEPTH];
  cnt_t        pcq_wr;
  cnt_t        pcq_rd;

  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  cnt_t        wr_ptr;
  cnt_t        rd_ptr;

  cnt_t        fifo_count;
  logic [CW:0] used;
  logic        fifo_empty;
  logic        credit_ok;
  logic        accept;
  logic        rsp;
  logic        push;
  logic        pop;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_count == '0);
  assign used       = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = (used < DEPTH_C);

  assign o_imem_req  = i_fetch_en & credit_ok & ~i_br_valid & ~i_reset;
  assign o_imem_addr = fetch_pc;

  assign accept = o_imem_req & i_imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp    = i_imem_rvalid & (inflight != '0);
  assign push   = rsp & (discard == '0) & ~i_br_valid;
  assign pop    = o_instr_valid & i_decode_ready & ~i_br_valid;

  assign o_instr_valid = ~fifo_empty;
  assign o_instr = fifo_empty ? '0 : fifo_instr[rd_ptr[AW-1:0]];
  assign o_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr[AW-1:0]];

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (i_br_valid)
        fetch_pc <= i_br_addr;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;

      inflight <= inflight + cnt_t'(accept) - cnt_t'(rsp);
      if (accept) pcq_wr <= pcq_wr + cnt_t'(1);
      if (rsp)    pcq_rd <= pcq_rd + cnt_t'(1);

      // Everything still outstanding after this cycle belongs to the old path
      if (i_br_valid)
        discard <= inflight - cnt_t'(rsp);
      else if (rsp && discard != '0)
        discard <= discard - cnt_t'(1);

      if (i_br_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + cnt_t'(1);
        if (pop)  rd_ptr <= rd_ptr + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (accept)
      pcq[pcq_wr[AW-1:0]] <= fetch_pc;
    if (push) begin
      fifo_instr[wr_ptr[AW-1:0]] <= i_imem_rdata;
      fifo_pc[wr_ptr[AW-1:0]]    <= pcq[pcq_rd[AW-1:0]];
    end
  end

endmodule
